// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Multi-cycle control FSM for the 16-bit accumulator/register datapath.
// It sequences fetch, decode, execute, memory and write-back from the latched
// IR opcode and the isZero flag, and it supports run/halt.
//
// Build option: define ILLEGAL_OP_TRAP_EN to send undefined opcodes to a
// terminal TRAP state. When it is not defined, those opcodes act as a NOP
// and Trap stays 0.
//
// Ports:
//   Clock        rising-edge clock
//   Reset        synchronous active-low reset (0 = reset)
//   Run          start/continue; sampled at instruction boundaries
//   IR[15:0]     instruction register; opcode = IR[15:12]
//   isZero       latched zero flag from the datapath
//   RegWrite .. IorM   single-bit datapath enables/selects
//   ALUctrl[2:0] 0=AND 1=ADD 2=SUB 3=OR
//   jControl[1:0] 0=PC+1 1=branch target 2=jump target
//   destAddr[1:0] 0=rd field 2=link register
//   destData[2:0] 0=ALU_Out 1=M 2=PC
//   Halted       HALT executed (terminal until Reset)
//   Trap         illegal opcode trapped (terminal until Reset)
//   State[3:0]   current state code, for debug
module multicycle_control_unit #(
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Run,
    input  logic [15:0] IR,
    input  logic        isZero,
    output logic        RegWrite,
    output logic        isZeroWrite,
    output logic        IRwrite,
    output logic        ItypeSel,
    output logic        Bsel,
    output logic        Asel,
    output logic        Bwrite,
    output logic        Awrite,
    output logic        Mwrite,
    output logic        ALUwrite,
    output logic        PCwrite,
    output logic        MemWrite,
    output logic        IorM,
    output logic [2:0]  ALUctrl,
    output logic [1:0]  jControl,
    output logic [1:0]  destAddr,
    output logic [2:0]  destData,
    output logic        Halted,
    output logic        Trap,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EX_ALU   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_HALT     = 4'd11,
        S_TRAP     = 4'd12,
        S_SW_DATA  = 4'd13
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_BZ   = 4'd7;
    localparam logic [3:0] OP_J    = 4'd8;
    localparam logic [3:0] OP_JAL  = 4'd9;

    state_t     state_q;
    state_t     state_d;
    state_t     boundary;
    logic [3:0] opcode;
    logic       unused_ir_bits;

    assign opcode         = IR[15:12];
    assign unused_ir_bits = ^IR[11:0];
    assign State          = state_q;

    // An instruction boundary parks in IDLE when Run has been dropped.
    assign boundary = Run ? S_FETCH : S_IDLE;

    // State register
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = Run ? S_FETCH : S_IDLE;
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                // HALT_OPCODE is checked first so a remapped halt still wins.
                if (opcode == HALT_OPCODE) begin
                    state_d = S_HALT;
                end else begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: state_d = S_EX_ALU;
                        OP_LW, OP_SW:                           state_d = S_MEM_ADDR;
                        OP_BZ:                                  state_d = S_BRANCH;
                        OP_J, OP_JAL:                           state_d = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
                        default:                                state_d = S_TRAP;
`else
                        default:                                state_d = boundary;
`endif
                    endcase
                end
            end
            S_EX_ALU:   state_d = S_ALU_WB;
            S_ALU_WB:   state_d = boundary;
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_SW_DATA;
            S_MEM_RD:   state_d = S_MEM_WB;
            S_MEM_WB:   state_d = boundary;
            S_SW_DATA:  state_d = S_MEM_WR;
            S_MEM_WR:   state_d = boundary;
            S_BRANCH:   state_d = boundary;
            S_JUMP:     state_d = boundary;
            S_HALT:     state_d = S_HALT;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
    end

    // Moore output decode from the registered state (plus opcode/isZero)
    always_comb begin
        RegWrite    = 1'b0;
        isZeroWrite = 1'b0;
        IRwrite     = 1'b0;
        ItypeSel    = 1'b0;
        Bsel        = 1'b0;
        Asel        = 1'b0;
        Bwrite      = 1'b0;
        Awrite      = 1'b0;
        Mwrite      = 1'b0;
        ALUwrite    = 1'b0;
        PCwrite     = 1'b0;
        MemWrite    = 1'b0;
        IorM        = 1'b0;
        ALUctrl     = 3'd1;
        jControl    = 2'd0;
        destAddr    = 2'd0;
        destData    = 3'd0;
        Halted      = 1'b0;
        Trap        = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRwrite = 1'b1;
                PCwrite = 1'b1;
            end
            S_DECODE: begin
                Awrite = 1'b1;
                Bwrite = 1'b1;
                // I-type operands take the sign-extended immediate on B.
                if (opcode == OP_ADDI || opcode == OP_LW || opcode == OP_SW) begin
                    Bsel     = 1'b1;
                    ItypeSel = 1'b1;
                end
            end
            S_EX_ALU: begin
                ALUwrite    = 1'b1;
                isZeroWrite = 1'b1;
                case (opcode)
                    OP_SUB:  ALUctrl = 3'd2;
                    OP_AND:  ALUctrl = 3'd0;
                    OP_OR:   ALUctrl = 3'd3;
                    default: ALUctrl = 3'd1;
                endcase
            end
            S_ALU_WB: begin
                RegWrite = 1'b1;
            end
            S_MEM_ADDR: begin
                ALUwrite = 1'b1;
            end
            S_MEM_RD: begin
                IorM   = 1'b1;
                Mwrite = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                destData = 3'd1;
            end
            S_SW_DATA: begin
                // Reload A from the rd port so the store data comes from A.
                Asel   = 1'b1;
                Awrite = 1'b1;
            end
            S_MEM_WR: begin
                IorM     = 1'b1;
                MemWrite = 1'b1;
            end
            S_BRANCH: begin
                PCwrite  = isZero;
                jControl = 2'd1;
            end
            S_JUMP: begin
                PCwrite  = 1'b1;
                jControl = 2'd2;
                // PC was already incremented in FETCH, so link that value.
                if (opcode == OP_JAL) begin
                    RegWrite = 1'b1;
                    destData = 3'd2;
                    destAddr = 2'd2;
                end
            end
            S_HALT: begin
                Halted = 1'b1;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP: begin
                Trap = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. Expected per-cycle state
// and control vectors are queued as each instruction is issued, then popped
// and compared cycle by cycle.
module tb_multicycle_control_unit;

    logic        Clock;
    logic        Reset;
    logic        Run;
    logic [15:0] IR;
    logic        isZero;
    logic        RegWrite, isZeroWrite, IRwrite, ItypeSel, Bsel, Asel;
    logic        Bwrite, Awrite, Mwrite, ALUwrite, PCwrite, MemWrite, IorM;
    logic [2:0]  ALUctrl;
    logic [1:0]  jControl;
    logic [1:0]  destAddr;
    logic [2:0]  destData;
    logic        Halted;
    logic        Trap;
    logic [3:0]  State;

    typedef struct packed {
        logic       reg_write;
        logic       iz_write;
        logic       ir_write;
        logic       itype_sel;
        logic       b_sel;
        logic       a_sel;
        logic       b_write;
        logic       a_write;
        logic       m_write;
        logic       alu_write;
        logic       pc_write;
        logic       mem_write;
        logic       iorm;
        logic [2:0] alu_ctrl;
        logic [1:0] j_ctrl;
        logic [1:0] dest_addr;
        logic [2:0] dest_data;
        logic       halted;
        logic       trap;
    } ctl_t;

    typedef struct packed {
        logic [3:0] st;
        ctl_t       ctl;
    } exp_t;

    exp_t sb[$];
    ctl_t dut_ctl;
    int   n_tests = 0;
    int   n_fail  = 0;

    assign dut_ctl = {RegWrite, isZeroWrite, IRwrite, ItypeSel, Bsel, Asel,
                      Bwrite, Awrite, Mwrite, ALUwrite, PCwrite, MemWrite, IorM,
                      ALUctrl, jControl, destAddr, destData, Halted, Trap};

    multicycle_control_unit dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .IR(IR), .isZero(isZero),
        .RegWrite(RegWrite), .isZeroWrite(isZeroWrite), .IRwrite(IRwrite),
        .ItypeSel(ItypeSel), .Bsel(Bsel), .Asel(Asel), .Bwrite(Bwrite),
        .Awrite(Awrite), .Mwrite(Mwrite), .ALUwrite(ALUwrite),
        .PCwrite(PCwrite), .MemWrite(MemWrite), .IorM(IorM),
        .ALUctrl(ALUctrl), .jControl(jControl), .destAddr(destAddr),
        .destData(destData), .Halted(Halted), .Trap(Trap), .State(State)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference control vector for a state, independent of the DUT.
    function automatic ctl_t exp_ctl(input logic [3:0] st, input logic [3:0] op, input logic iz);
        ctl_t c;
        c = '0;
        c.alu_ctrl = 3'd1;
        case (st)
            4'd1:  begin c.ir_write = 1'b1; c.pc_write = 1'b1; end
            4'd2:  begin
                c.a_write = 1'b1; c.b_write = 1'b1;
                if (op == 4'd4 || op == 4'd5 || op == 4'd6) begin
                    c.b_sel = 1'b1; c.itype_sel = 1'b1;
                end
            end
            4'd3:  begin
                c.alu_write = 1'b1; c.iz_write = 1'b1;
                c.alu_ctrl = (op == 4'd1) ? 3'd2 : (op == 4'd2) ? 3'd0 :
                             (op == 4'd3) ? 3'd3 : 3'd1;
            end
            4'd4:  c.reg_write = 1'b1;
            4'd5:  c.alu_write = 1'b1;
            4'd6:  begin c.iorm = 1'b1; c.m_write = 1'b1; end
            4'd7:  begin c.reg_write = 1'b1; c.dest_data = 3'd1; end
            4'd8:  begin c.iorm = 1'b1; c.mem_write = 1'b1; end
            4'd9:  begin c.pc_write = iz; c.j_ctrl = 2'd1; end
            4'd10: begin
                c.pc_write = 1'b1; c.j_ctrl = 2'd2;
                if (op == 4'd9) begin
                    c.reg_write = 1'b1; c.dest_data = 3'd2; c.dest_addr = 2'd2;
                end
            end
            4'd11: c.halted = 1'b1;
            4'd12: c.trap = 1'b1;
            4'd13: begin c.a_sel = 1'b1; c.a_write = 1'b1; end
            default: begin end
        endcase
        return c;
    endfunction

    task automatic push_state(input logic [3:0] st, input logic [3:0] op, input logic iz);
        exp_t e;
        e.st  = st;
        e.ctl = exp_ctl(st, op, iz);
        sb.push_back(e);
    endtask

    // Queue the FETCH-to-FETCH state trace expected for one instruction.
    task automatic push_instr(input logic [15:0] ir, input logic iz);
        logic [3:0] op;
        op = ir[15:12];
        push_state(4'd1, op, iz);
        push_state(4'd2, op, iz);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
                push_state(4'd3, op, iz); push_state(4'd4, op, iz);
            end
            4'd5: begin
                push_state(4'd5, op, iz); push_state(4'd6, op, iz); push_state(4'd7, op, iz);
            end
            4'd6: begin
                push_state(4'd5, op, iz); push_state(4'd13, op, iz); push_state(4'd8, op, iz);
            end
            4'd7:       push_state(4'd9, op, iz);
            4'd8, 4'd9: push_state(4'd10, op, iz);
            4'hF:       push_state(4'd11, op, iz);
`ifdef ILLEGAL_OP_TRAP_EN
            default:    push_state(4'd12, op, iz);
`else
            default: begin end
`endif
        endcase
    endtask

    // Pop and compare one entry per clock; optionally drop Run in a given state.
    task automatic drain(input string name, input int drop_st);
        exp_t e;
        int   cyc;
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq($sformatf("%s c%0d state", name, cyc), 32'(State), 32'(e.st));
            check_eq($sformatf("%s c%0d ctl", name, cyc), 32'(dut_ctl), 32'(e.ctl));
            check_eq($sformatf("%s c%0d mem_reg_excl", name, cyc), 32'(MemWrite & RegWrite), 32'd0);
            if (drop_st >= 0 && int'(e.st) == drop_st) Run = 1'b0;
            @(posedge Clock);
            #1;
            cyc++;
        end
    endtask

    task automatic run_instr(input string name, input logic [15:0] ir, input logic iz);
        IR     = ir;
        isZero = iz;
        push_instr(ir, iz);
        drain(name, -1);
    endtask

    task automatic check_reset_state(input string name);
        check_eq({name, " state"}, 32'(State), 32'd0);
        check_eq({name, " ctl"}, 32'(dut_ctl), 32'(exp_ctl(4'd0, 4'd0, 1'b0)));
    endtask

    initial begin
        Reset  = 1'b0;
        Run    = 1'b1;
        IR     = 16'h0000;
        isZero = 1'b0;

        // Reset held for two edges with Run high.
        for (int i = 0; i < 2; i++) begin
            @(posedge Clock);
            #1;
            check_reset_state($sformatf("reset%0d", i));
        end
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check_eq("release fetch", 32'(State), 32'd1);

        run_instr("add",    16'h0123, 1'b0);
        run_instr("sub",    16'h1123, 1'b0);
        run_instr("and",    16'h2123, 1'b1);
        run_instr("or",     16'h3123, 1'b0);
        run_instr("addi",   16'h4107, 1'b0);
        run_instr("lw",     16'h5104, 1'b0);
        run_instr("sw",     16'h6104, 1'b0);
        run_instr("bz_t",   16'h7005, 1'b1);
        run_instr("bz_nt",  16'h7005, 1'b0);
        run_instr("j",      16'h8020, 1'b0);
        run_instr("jal",    16'h9010, 1'b0);

        // Run dropped during EX_ALU: write-back completes, then IDLE.
        IR = 16'h0123;
        push_instr(16'h0123, 1'b0);
        push_state(4'd0, 4'd0, 1'b0);
        drain("run_drop", 3);
        check_eq("idle hold", 32'(State), 32'd0);
        Run = 1'b1;
        @(posedge Clock);
        #1;
        check_eq("resume fetch", 32'(State), 32'd1);

        // HALT is terminal: hold for 10 extra cycles, then reset clears it.
        IR = 16'hF000;
        push_instr(16'hF000, 1'b0);
        for (int i = 0; i < 10; i++) push_state(4'd11, 4'hF, 1'b0);
        drain("halt", -1);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        check_reset_state("halt_reset");
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check_eq("post_halt fetch", 32'(State), 32'd1);

        // Undefined opcode.
        IR = 16'hB000;
        push_instr(16'hB000, 1'b0);
`ifdef ILLEGAL_OP_TRAP_EN
        for (int i = 0; i < 5; i++) push_state(4'd12, 4'hB, 1'b0);
        drain("trap", -1);
        check_eq("trap held", 32'(Trap), 32'd1);
`else
        drain("nop", -1);
        check_eq("nop refetch", 32'(State), 32'd1);
        check_eq("nop trap", 32'(Trap), 32'd0);
`endif

        // Reset mid-instruction aborts with no further enables.
        IR = 16'h5104;
        @(posedge Clock);
        #1;
        check_eq("mid decode", 32'(State), 32'd2);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        check_reset_state("mid_reset");
        Reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle control FSM that drives every control input of the 16-bit accumulator/register datapath (Processor_Integration_6) from the latched IR opcode and the isZero flag.
- Sits directly upstream of the datapath and replaces bench-driven control.
- Sequences fetch, decode, execute, memory and write-back; supports run/halt.

Parameters:
- HALT_OPCODE, 4'hF, IR[15:12] value that halts the machine.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-low reset (0 = reset)
- Run  in  1  start/continue execution; sampled at instruction boundaries
- IR  in  16  instruction register from datapath; opcode = IR[15:12]
- isZero  in  1  latched zero flag from datapath
- RegWrite, isZeroWrite, IRwrite, ItypeSel, Bsel, Asel, Bwrite, Awrite, Mwrite, ALUwrite, PCwrite, MemWrite, IorM  out  1 each  datapath controls
- ALUctrl  out  3  0=AND, 1=ADD, 2=SUB, 3=OR
- jControl  out  2  0=PC+1, 1=branch target, 2=jump target
- destAddr  out  2  0=IR rd field, 2=link register
- destData  out  3  0=ALU_Out, 1=M, 2=PC
- Halted  out  1  HALT executed
- Trap  out  1  illegal opcode (see Optional Feature)
- State  out  4  current state code, debug

Behaviour:
- Mux meanings:
  - Asel: 0 = rs read, 1 = rd read.
  - Bsel: 0 = rt read, 1 = immediate.
  - ItypeSel: 1 = sign-extend, 0 = zero-extend.
  - IorM: 0 = PC address, 1 = ALU_Out address.
- Outputs are Moore-decoded from State, plus the IR opcode (ALUctrl) and isZero (BRANCH only).
- Default for any state not listed: all enables 0, selects 0, ALUctrl=1, Halted=0, Trap=0.
- Reset: on a Clock edge with Reset=0, State becomes IDLE and all outputs take their defaults. Reset mid-instruction aborts the instruction with no partial writes afterward.
- States and codes:
  - IDLE(0): wait; if Run=1, go to FETCH.
  - FETCH(1): IorM=0, IRwrite=1, PCwrite=1, jControl=0. Next state DECODE.
  - DECODE(2): Asel=0, Awrite=1, Bwrite=1.
    - Bsel=1 and ItypeSel=1 for opcodes 4, 5, 6; otherwise Bsel=0.
    - Dispatch on opcode:
      - 0–4 (ADD, SUB, AND, OR, ADDI) → EX_ALU
      - 5 (LW), 6 (SW) → MEM_ADDR
      - 7 (BZ) → BRANCH
      - 8 (J), 9 (JAL) → JUMP
      - HALT_OPCODE → HALT
      - others → illegal handling
  - EX_ALU(3): ALUwrite=1, isZeroWrite=1. ALUctrl: op0→1, op1→2, op2→0, op3→3, op4→1. Next ALU_WB.
  - ALU_WB(4): RegWrite=1, destData=0, destAddr=0. Next FETCH.
  - MEM_ADDR(5): ALUctrl=1, ALUwrite=1. LW → MEM_RD; SW → SW_DATA.
  - MEM_RD(6): IorM=1, Mwrite=1. Next MEM_WB.
  - MEM_WB(7): RegWrite=1, destData=1, destAddr=0. Next FETCH.
  - SW_DATA(13): Asel=1, Awrite=1. Next MEM_WR.
  - MEM_WR(8): IorM=1, MemWrite=1 (stores A). Next FETCH.
  - BRANCH(9): PCwrite=isZero, jControl=1. Next FETCH.
  - JUMP(10): PCwrite=1, jControl=2. For JAL, also RegWrite=1, destData=2, destAddr=2 in the same cycle (links the already-incremented PC). Next FETCH.
  - HALT(11): Halted=1; terminal until Reset.
  - TRAP(12): Trap=1; terminal until Reset.
- Latency in cycles, FETCH to FETCH: R-type/ADDI 4, LW 5, SW 5, BZ/J/JAL 3.
- Any transition into FETCH goes to IDLE instead when Run=0. Dropping Run mid-instruction always completes the current instruction.
- IR is only written in FETCH, so the opcode is stable from DECODE through write-back.
- Never assert MemWrite and RegWrite in the same cycle. Never assert IRwrite outside FETCH.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: opcodes 0xA–0xE (excluding HALT_OPCODE) go from DECODE to TRAP; Trap=1 until Reset; no further enables asserted.
- Undefined: these opcodes act as a NOP (DECODE→FETCH, 2 cycles) and Trap is tied 0.

Test Plan:
- Reset=0 for 2 cycles with Run=1, IR=16'h0000 → State=0, all enables 0, ALUctrl=1, Halted=0, Trap=0. Release Reset with Run=1 → State=1 after one edge.
- ADD (IR=16'h0123), Run=1 → FETCH (IRwrite=1, PCwrite=1, jControl=0), DECODE (Awrite=Bwrite=1, Bsel=0), EX_ALU (ALUwrite=1, isZeroWrite=1, ALUctrl=1), ALU_WB (RegWrite=1, destData=0); FETCH again at cycle 5. Repeat with SUB → ALUctrl=2.
- LW (IR=16'h5104) → DECODE Bsel=1, ItypeSel=1; MEM_RD IorM=1, Mwrite=1; MEM_WB RegWrite=1, destData=1. SW (16'h6104) → SW_DATA Asel=1, Awrite=1, then MEM_WR IorM=1, MemWrite=1.
- BZ (16'h7005) with isZero=1 → BRANCH PCwrite=1, jControl=1. With isZero=0 → PCwrite=0. JAL (16'h9010) → RegWrite=1, destData=2, destAddr=2, PCwrite=1, jControl=2 in one cycle.
- HALT (16'hF000) → Halted=1 held 10 cycles; Reset=0 clears it. Run dropped during EX_ALU → ALU_WB completes, then State=0.
- IR=16'hB000 → with ILLEGAL_OP_TRAP_EN, Trap=1 and State=12 persist; without it, State returns to 1 two cycles after FETCH and Trap=0.
